uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver; the serial-input counterpart of the core's Tx transmitter.
- Deserialises the Rx line into bytes and holds each byte in a one-entry buffer until the core or peripheral bus reads it.
- Flags framing errors and overruns with sticky bits.
- Sits beside the transmitter in the core's I/O subsystem, on the same clock.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per bit period (100 MHz / 115200 baud). Legal range is 4 or more.
- HALF_BIT, CLKS_PER_BIT/2: start-bit mid-point offset, derived; do not override.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- Rx  in  1  serial input, idle high, asynchronous to clk.
- rd_en  in  1  one-cycle pulse; consumes the buffered byte.
- err_clr  in  1  one-cycle pulse; clears frame_err and overrun.
- rx_data  out  8  last received byte.
- rx_valid  out  1  buffered byte available.
- frame_err  out  1  sticky; stop bit sampled low.
- overrun  out  1  sticky; byte completed while rx_valid was still set.
- busy  out  1  high in every state except IDLE.

Behaviour:
- One clock. reset is asynchronous and active-high.
- Reset values: rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0. State=IDLE, counters=0. Both synchronizer flops reset to 1.
- Rx passes through a 2-flop synchronizer; rx_s is the second stage. All decisions use rx_s only.
- States: IDLE, START, DATA, STOP, WAIT_HIGH. Use a bit-period counter cnt with $clog2(CLKS_PER_BIT) bits and a bit index idx of 3 bits.
- IDLE: when rx_s==0, go to START with cnt=0.
- START: cnt increments each cycle. When cnt==HALF_BIT-1, sample rx_s:
  - 0: go to DATA, cnt=0, idx=0.
  - 1: treat as a glitch and return to IDLE. Nothing is reported.
- DATA: when cnt==CLKS_PER_BIT-1, sample rx_s into shift[idx] (LSB first) and reset cnt.
  - On idx==7, go to STOP; otherwise increment idx.
- STOP: when cnt==CLKS_PER_BIT-1, sample rx_s.
  - 1: rx_data<=shift and rx_valid<=1. If rx_valid was already 1 and rd_en is not asserted this cycle, overrun<=1; the new byte overwrites the old one. Go to IDLE.
  - 0: frame_err<=1. rx_data and rx_valid are unchanged. Go to WAIT_HIGH.
- WAIT_HIGH: remain until rx_s==1 (break or stuck-low line), then go to IDLE.
- Return to IDLE happens at stop-bit mid-point, so back-to-back frames with a single stop bit are received.
- rd_en: clears rx_valid at the next edge. rd_en with rx_valid=0 is ignored.
  - If rd_en coincides with a new byte completing: rx_valid stays 1, rx_data takes the new byte, and overrun is not set.
- err_clr: clears frame_err and overrun at the next edge. If a new error event occurs in the same cycle, the new event wins (bit ends up set).
- rd_en and err_clr are independent of each other and of the receive FSM state.
- Latency: rx_valid rises HALF_BIT + 9*CLKS_PER_BIT + 2 to +4 cycles after the Rx falling edge at the input pin. A bench may allow ±3 cycles.
- Asserting reset mid-frame aborts the frame immediately. No partial byte is ever delivered.
- busy=1 in START, DATA, STOP and WAIT_HIGH.

Test Plan:
- Reset with CLKS_PER_BIT=16 and Rx=1 -> all outputs 0, busy=0. Holding Rx=1 for 1000 cycles -> nothing changes.
- Drive 0xA5 (start, 1,0,1,0,0,1,0,1, stop) at 16 clks/bit -> rx_valid=1 and rx_data=0xA5 within 8+144+3 cycles of the start edge; rx_valid stays 1 until an rd_en pulse, then is 0 the next cycle.
- Pull Rx low for 4 cycles, then high -> busy returns to 0, rx_valid stays 0, frame_err stays 0.
- Send a frame with data 0x5A and stop bit 0, hold Rx low for 40 cycles, then release -> frame_err=1, rx_valid=0, FSM waits in WAIT_HIGH. Next, 0x3C is received correctly. err_clr -> frame_err=0.
- Send 0x11 then 0x22 back-to-back without rd_en -> rx_data=0x22, overrun=1. Repeat with rd_en pulsed on the exact cycle 0x22 completes -> overrun stays 0.
- Assert reset during data bit 4 of a frame -> outputs return to reset values asynchronously. The remaining bits are ignored, and a fresh 0xFF frame sent afterwards yields rx_data=0xFF.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver.
//
// Deserialises the asynchronous Rx line into bytes, LSB first, and holds the
// most recent byte in a one-entry buffer until it is consumed with rd_en.
// Framing errors (stop bit sampled low) and overruns (a byte completing while
// the buffer is still full) are reported through sticky flags that stay set
// until err_clr.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   Rx         serial input, idle high, asynchronous to clk
//   rd_en      one-cycle pulse, consumes the buffered byte
//   err_clr    one-cycle pulse, clears frame_err and overrun
//   rx_data    last received byte
//   rx_valid   buffered byte available
//   frame_err  sticky, stop bit sampled low
//   overrun    sticky, byte completed while rx_valid was still set
//   busy       high whenever the receiver is not idle
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit period (4 or more)
//   HALF_BIT      start-bit mid-point offset, derived from CLKS_PER_BIT
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Rx,
    input  logic       rd_en,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    // Counter wide enough to reach CLKS_PER_BIT-1.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    // Terminal counts: end of a full bit period, and the start-bit mid-point.
    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // Internal state
    // -------------------------------------------------------------------------
    logic [1:0]       rx_sync_r;     // [0] first stage, [1] second stage
    logic             rx_s;          // synchronised Rx, the only Rx used below

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;         // cycles elapsed in the current bit period
    logic [2:0]       idx_r;         // index of the data bit being received
    logic [7:0]       shift_r;       // data bits assembled LSB first

    logic [7:0]       rx_data_r;
    logic             rx_valid_r;
    logic             frame_err_r;
    logic             overrun_r;
    logic             busy_r;

    // -------------------------------------------------------------------------
    // Input synchroniser
    // -------------------------------------------------------------------------
    // Two-flop synchroniser for the asynchronous Rx line; resets to idle-high
    // so that reset release never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync_r <= 2'b11;
        end else begin
            rx_sync_r <= {rx_sync_r[0], Rx};
        end
    end

    assign rx_s = rx_sync_r[1];

    // -------------------------------------------------------------------------
    // Receive FSM, byte buffer and sticky status
    // -------------------------------------------------------------------------
    // Single FSM process. The host-side clears (rd_en, err_clr) are applied
    // first so that a receive event later in the same cycle overrides them:
    // a byte completing alongside rd_en keeps rx_valid set, and a fresh error
    // alongside err_clr leaves the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            idx_r       <= 3'd0;
            shift_r     <= 8'h00;
            rx_data_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            // Host-side consume and error clear, independent of FSM state.
            if (rd_en) begin
                rx_valid_r <= 1'b0;
            end
            if (err_clr) begin
                frame_err_r <= 1'b0;
                overrun_r   <= 1'b0;
            end

            case (state_r)
                // Line idle: a low level on the synchronised line is a
                // candidate start bit.
                IDLE: begin
                    if (rx_s == 1'b0) begin
                        state_r <= START;
                        cnt_r   <= CNT_ZERO;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end

                // Confirm the start bit at its mid-point. A line that has
                // returned high by then was a glitch and is dropped silently.
                START: begin
                    if (cnt_r == CNT_HALF_END) begin
                        cnt_r <= CNT_ZERO;
                        if (rx_s == 1'b0) begin
                            state_r <= DATA;
                            idx_r   <= 3'd0;
                        end else begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                // Having aligned to the start-bit mid-point, each full bit
                // period lands the sample in the middle of the next data bit.
                DATA: begin
                    if (cnt_r == CNT_BIT_END) begin
                        cnt_r          <= CNT_ZERO;
                        shift_r[idx_r] <= rx_s;
                        if (idx_r == 3'd7) begin
                            state_r <= STOP;
                        end else begin
                            idx_r <= idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                // Stop-bit mid-point. Returning to IDLE here, rather than at
                // the end of the stop bit, leaves half a bit of slack so that
                // back-to-back frames with a single stop bit are caught.
                STOP: begin
                    if (cnt_r == CNT_BIT_END) begin
                        cnt_r <= CNT_ZERO;
                        if (rx_s == 1'b1) begin
                            rx_data_r  <= shift_r;
                            rx_valid_r <= 1'b1;
                            // Reading in the completing cycle frees the slot,
                            // so only an unread buffer counts as an overrun.
                            if (rx_valid_r && !rd_en) begin
                                overrun_r <= 1'b1;
                            end
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            // Buffer untouched: a badly framed byte is never
                            // delivered.
                            frame_err_r <= 1'b1;
                            state_r     <= WAIT_HIGH;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                // Break or stuck-low line: hold off until the line is idle
                // again so the low level is not mistaken for a start bit.
                WAIT_HIGH: begin
                    if (rx_s == 1'b1) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        busy_r  <= 1'b1;
                    end
                end

                default: begin
                    state_r <= IDLE;
                    cnt_r   <= CNT_ZERO;
                    idx_r   <= 3'd0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs, all driven straight from registers
    // -------------------------------------------------------------------------
    assign rx_data   = rx_data_r;
    assign rx_valid  = rx_valid_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx at 16 clocks per bit.
// Frames are driven on the Rx pin by send_frame; each byte that should be
// delivered is pushed to exp_q when its frame is driven and popped when the
// receiver presents it. Inputs change and outputs are sampled on the falling
// clock edge.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int TIMEOUT = 400;

    logic       clk;
    logic       reset;
    logic       Rx;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];

    uart_rx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .Rx       (Rx),
        .rd_en    (rd_en),
        .err_clr  (err_clr),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one 8N1 frame starting at the current falling edge. Bytes that
    // the receiver should deliver are pushed to the scoreboard.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input bit expect_it);
        if (expect_it) exp_q.push_back(data);
        Rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            Rx = data[i];
            repeat (CPB) @(negedge clk);
        end
        Rx = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    // Count falling edges until rx_valid is seen high, bounded by TIMEOUT.
    task automatic wait_valid(output int n);
        n = 0;
        while (rx_valid !== 1'b1 && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; Rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({rx_data, rx_valid, frame_err, overrun, busy} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected %h",
                     {rx_data, rx_valid, frame_err, overrun, busy}, 12'h000);
        end
        repeat (1000) @(negedge clk);
        n_tests++;
        if ({rx_data, rx_valid, frame_err, overrun, busy} !== 12'h000) begin
            n_fail++;
            $display("FAIL idle_1000: got %h expected %h",
                     {rx_data, rx_valid, frame_err, overrun, busy}, 12'h000);
        end
    endtask

    task automatic test_basic();
        int n;
        logic [7:0] exp;
        fork
            send_frame(8'hA5, 1'b1, 1'b1);
            wait_valid(n);
        join
        n_tests++;
        if (n < 152 || n > 158) begin
            n_fail++;
            $display("FAIL a5_latency: got %0d cycles expected 152..158", n);
        end
        exp = exp_q.pop_front();
        n_tests++;
        if (rx_data !== exp) begin
            n_fail++;
            $display("FAIL a5_data: got %h expected %h", rx_data, exp);
        end
        repeat (20) @(negedge clk);
        n_tests++;
        if (rx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL a5_hold: got %b expected 1", rx_valid);
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        n_tests++;
        if (rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL a5_consume: got %b expected 0", rx_valid);
        end
    endtask

    task automatic test_glitch();
        Rx = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_busy: got %b expected 1", busy);
        end
        Rx = 1'b1;
        repeat (20) @(negedge clk);
        n_tests++;
        if ({busy, rx_valid, frame_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL glitch_idle: got %b expected 000",
                     {busy, rx_valid, frame_err});
        end
    endtask

    task automatic test_frame_err();
        int n;
        logic [7:0] exp;
        send_frame(8'h5A, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        n_tests++;
        if ({frame_err, rx_valid, busy} !== 3'b101) begin
            n_fail++;
            $display("FAIL ferr_flags: got %b expected 101",
                     {frame_err, rx_valid, busy});
        end
        Rx = 1'b1;
        repeat (10) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ferr_release: got %b expected 0", busy);
        end
        fork
            send_frame(8'h3C, 1'b1, 1'b1);
            wait_valid(n);
        join
        exp = exp_q.pop_front();
        n_tests++;
        if (n >= TIMEOUT || rx_data !== exp || frame_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ferr_next: got data %h ferr %b (%0d cyc) expected data %h ferr 1",
                     rx_data, frame_err, n, exp);
        end
        rd_en = 1'b1; err_clr = 1'b1;
        @(negedge clk);
        rd_en = 1'b0; err_clr = 1'b0;
        n_tests++;
        if ({frame_err, rx_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL ferr_clear: got %b expected 00", {frame_err, rx_valid});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        int n;
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        // The first byte is overwritten unread.
        void'(exp_q.pop_front());
        exp = exp_q.pop_front();
        n_tests++;
        if ({rx_valid, overrun, rx_data} !== {1'b1, 1'b1, exp}) begin
            n_fail++;
            $display("FAIL b2b_overrun: got v%b o%b %h expected v1 o1 %h",
                     rx_valid, overrun, rx_data, exp);
        end
        rd_en = 1'b1; err_clr = 1'b1;
        @(negedge clk);
        rd_en = 1'b0; err_clr = 1'b0;
        n_tests++;
        if ({rx_valid, overrun} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_clear: got %b expected 00", {rx_valid, overrun});
        end
        // Second pass: rd_en lands on the edge that completes 0x22, which is
        // exactly one frame (10 bit periods) after 0x11 completed.
        fork
            begin
                send_frame(8'h11, 1'b1, 1'b1);
                send_frame(8'h22, 1'b1, 1'b1);
            end
            begin
                wait_valid(n);
                exp = exp_q.pop_front();
                n_tests++;
                if (n >= TIMEOUT || rx_data !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_first: got %h (%0d cyc) expected %h",
                             rx_data, n, exp);
                end
                repeat (10 * CPB - 1) @(negedge clk);
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
                exp = exp_q.pop_front();
                n_tests++;
                if ({rx_valid, overrun, rx_data} !== {1'b1, 1'b0, exp}) begin
                    n_fail++;
                    $display("FAIL b2b_rd_same_cycle: got v%b o%b %h expected v1 o0 %h",
                             rx_valid, overrun, rx_data, exp);
                end
            end
        join
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int n;
        logic [7:0] exp;
        // Leave a byte buffered so the reset has something to clear.
        fork
            send_frame(8'h81, 1'b1, 1'b1);
            wait_valid(n);
        join
        exp = exp_q.pop_front();
        n_tests++;
        if (n >= TIMEOUT || rx_data !== exp) begin
            n_fail++;
            $display("FAIL rst_pre: got %h (%0d cyc) expected %h", rx_data, n, exp);
        end
        // 0xF0 keeps the line high from bit 4 on, so nothing after the reset
        // looks like a start bit; the aborted byte must never appear.
        fork
            send_frame(8'hF0, 1'b1, 1'b0);
            begin
                repeat (5 * CPB + CPB / 2) @(negedge clk);
                n_tests++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rst_busy_before: got %b expected 1", busy);
                end
                #2 reset = 1'b1;
                #1;
                n_tests++;
                if ({rx_data, rx_valid, frame_err, overrun, busy} !== 12'h000) begin
                    n_fail++;
                    $display("FAIL rst_async: got %h expected %h",
                             {rx_data, rx_valid, frame_err, overrun, busy}, 12'h000);
                end
                @(negedge clk);
                reset = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        n_tests++;
        if ({rx_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_no_partial: got %b expected 00", {rx_valid, busy});
        end
        fork
            send_frame(8'hFF, 1'b1, 1'b1);
            wait_valid(n);
        join
        exp = exp_q.pop_front();
        n_tests++;
        if (n >= TIMEOUT || rx_data !== exp) begin
            n_fail++;
            $display("FAIL rst_after_ff: got %h (%0d cyc) expected %h", rx_data, n, exp);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
